// File: rtl/pcpi_pkg.sv
// Shared PCPI definitions: dispatcher states, MUL/DIV decode constants and the
// default claim window used by the dispatcher, coprocessors and the core.
package pcpi_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ISSUE = 3'd1,
        BUSY  = 3'd2,
        RESP  = 3'd3,
        GAP   = 3'd4
    } pcpi_state_e;

    localparam logic [6:0] PCPI_OPCODE        = 7'b0110011;
    localparam logic [6:0] PCPI_FUNCT7_MULDIV = 7'b0000001;
    localparam int         PCPI_TIMEOUT_DEF   = 16;

    function automatic logic pcpi_is_muldiv(input logic [31:0] insn);
        return (insn[6:0] == PCPI_OPCODE) && (insn[31:25] == PCPI_FUNCT7_MULDIV);
    endfunction

endpackage

// File: rtl/pcpi_resp_select.sv
// Lowest-index priority select over the coprocessor ready lines; returns the
// winning unit's write-enable and result.
module pcpi_resp_select
    import pcpi_pkg::*;
#(
    parameter int NUM_CP = 2
) (
    input  logic [NUM_CP-1:0]    cp_ready_i,
    input  logic [NUM_CP-1:0]    cp_wr_i,
    input  logic [32*NUM_CP-1:0] cp_rd_i,
    output logic                 sel_wr_o,
    output logic [31:0]          sel_rd_o,
    output logic                 any_ready_o
);

    // Walk from the top down so the lowest ready index overwrites last.
    always_comb begin
        sel_wr_o    = 1'b0;
        sel_rd_o    = 32'd0;
        any_ready_o = |cp_ready_i;
        for (int i = NUM_CP - 1; i >= 0; i--) begin
            if (cp_ready_i[i]) begin
                sel_wr_o = cp_wr_i[i];
                sel_rd_o = cp_rd_i[32*i +: 32];
            end
        end
    end

endmodule

// File: rtl/pcpi_dispatch.sv
// Registers a core PCPI request, broadcasts it to all coprocessors and returns
// the first responder's result, or pulses illegal if nobody claims it in time.
module pcpi_dispatch
    import pcpi_pkg::*;
#(
    parameter int NUM_CP  = 2,
    parameter int TIMEOUT = PCPI_TIMEOUT_DEF
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 pcpi_valid,
    input  logic [31:0]          pcpi_insn,
    input  logic [31:0]          pcpi_rs1,
    input  logic [31:0]          pcpi_rs2,
    output logic                 pcpi_wr,
    output logic [31:0]          pcpi_rd,
    output logic                 pcpi_wait,
    output logic                 pcpi_ready,
    output logic                 pcpi_illegal,
    output logic                 cp_valid,
    output logic [31:0]          cp_insn,
    output logic [31:0]          cp_rs1,
    output logic [31:0]          cp_rs2,
    input  logic [NUM_CP-1:0]    cp_wr,
    input  logic [32*NUM_CP-1:0] cp_rd,
    input  logic [NUM_CP-1:0]    cp_wait,
    input  logic [NUM_CP-1:0]    cp_ready
);

    localparam int             CW       = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0]  CNT_LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    pcpi_state_e  state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [31:0]  insn_q, insn_d, rs1_q, rs1_d, rs2_q, rs2_d;
    logic [31:0]  rd_q, rd_d;
    logic         wr_q, wr_d;
    logic         ill_q, ill_d;
    logic         wait_q;

    logic         sel_wr, any_ready;
    logic [31:0]  sel_rd;

    pcpi_resp_select #(.NUM_CP(NUM_CP)) u_sel (
        .cp_ready_i  (cp_ready),
        .cp_wr_i     (cp_wr),
        .cp_rd_i     (cp_rd),
        .sel_wr_o    (sel_wr),
        .sel_rd_o    (sel_rd),
        .any_ready_o (any_ready)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        insn_d  = insn_q;
        rs1_d   = rs1_q;
        rs2_d   = rs2_q;
        rd_d    = rd_q;
        wr_d    = wr_q;
        ill_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (pcpi_valid) begin
                    insn_d  = pcpi_insn;
                    rs1_d   = pcpi_rs1;
                    rs2_d   = pcpi_rs2;
                    cnt_d   = '0;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                // A completion beats both a claim and an expiring window.
                if (any_ready) begin
                    rd_d    = sel_rd;
                    wr_d    = sel_wr;
                    state_d = RESP;
                end else if (|cp_wait) begin
                    state_d = BUSY;
                end else if ((TIMEOUT != 0) && (cnt_q == CNT_LAST)) begin
                    ill_d   = 1'b1;
                    state_d = GAP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            BUSY: begin
                if (any_ready) begin
                    rd_d    = sel_rd;
                    wr_d    = sel_wr;
                    state_d = RESP;
                end
            end
            RESP:    state_d = GAP;
            GAP:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            insn_q  <= '0;
            rs1_q   <= '0;
            rs2_q   <= '0;
            rd_q    <= '0;
            wr_q    <= 1'b0;
            ill_q   <= 1'b0;
            wait_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            insn_q  <= insn_d;
            rs1_q   <= rs1_d;
            rs2_q   <= rs2_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            ill_q   <= ill_d;
            wait_q  <= |cp_wait;
        end
    end

    // Decoded straight from state so reset drops the broadcast without a clock.
    assign cp_valid     = (state_q == ISSUE) || (state_q == BUSY);
    assign cp_insn      = insn_q;
    assign cp_rs1       = rs1_q;
    assign cp_rs2       = rs2_q;
    assign pcpi_ready   = (state_q == RESP);
    assign pcpi_wr      = wr_q & pcpi_ready;
    assign pcpi_rd      = rd_q;
    assign pcpi_illegal = ill_q;
    assign pcpi_wait    = wait_q & cp_valid;

endmodule

// File: tb/tb_pcpi_dispatch.sv
// Directed bench for pcpi_dispatch: a behavioural multiplier on cp0, stub
// responders, timeout window, priority, back-to-back and mid-op reset.
module tb_pcpi_dispatch;
    import pcpi_pkg::*;

    localparam logic [31:0] I_MUL   = 32'h023100B3;
    localparam logic [31:0] I_MULH  = 32'h023110B3;
    localparam logic [31:0] I_MULHU = 32'h023130B3;
    localparam logic [31:0] I_OTHER = 32'h02314133;

    logic        clk = 1'b0;
    logic        reset;
    logic        pcpi_valid;
    logic [31:0] pcpi_insn, pcpi_rs1, pcpi_rs2;
    logic        pcpi_wr, pcpi_wait, pcpi_ready, pcpi_illegal;
    logic [31:0] pcpi_rd;
    logic        cp_valid;
    logic [31:0] cp_insn, cp_rs1, cp_rs2;
    logic [1:0]  cp_wr, cp_wait, cp_ready;
    logic [63:0] cp_rd;

    int total = 0;
    int bad   = 0;

    pcpi_dispatch #(.NUM_CP(2), .TIMEOUT(16)) dut (
        .clk(clk), .reset(reset),
        .pcpi_valid(pcpi_valid), .pcpi_insn(pcpi_insn), .pcpi_rs1(pcpi_rs1), .pcpi_rs2(pcpi_rs2),
        .pcpi_wr(pcpi_wr), .pcpi_rd(pcpi_rd), .pcpi_wait(pcpi_wait),
        .pcpi_ready(pcpi_ready), .pcpi_illegal(pcpi_illegal),
        .cp_valid(cp_valid), .cp_insn(cp_insn), .cp_rs1(cp_rs1), .cp_rs2(cp_rs2),
        .cp_wr(cp_wr), .cp_rd(cp_rd), .cp_wait(cp_wait), .cp_ready(cp_ready)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached (got hang, need finish)");
        $fatal(1);
    end

    task automatic clear_cp();
        cp_wr = '0; cp_wait = '0; cp_ready = '0; cp_rd = '0;
    endtask

    task automatic test_reset();
        reset = 1'b1; pcpi_valid = 1'b0; pcpi_insn = '0; pcpi_rs1 = '0; pcpi_rs2 = '0;
        clear_cp();
        repeat (2) @(negedge clk);
        total++; if (cp_valid !== 1'b0) begin bad++; $display("FAIL reset_cp_valid got=%b want=0", cp_valid); end
        total++; if ({pcpi_ready, pcpi_illegal, pcpi_wait, pcpi_wr} !== 4'b0) begin bad++; $display("FAIL reset_flags got=%b want=0000", {pcpi_ready, pcpi_illegal, pcpi_wait, pcpi_wr}); end
        total++; if (pcpi_rd !== 32'd0) begin bad++; $display("FAIL reset_rd got=%h want=0", pcpi_rd); end
        total++; if ({cp_insn, cp_rs1, cp_rs2} !== 96'd0) begin bad++; $display("FAIL reset_cp_regs got=%h want=0", {cp_insn, cp_rs1, cp_rs2}); end
        total++; if (dut.state_q !== IDLE) begin bad++; $display("FAIL reset_state got=%0d want=%0d", dut.state_q, IDLE); end
        reset = 1'b0;
        @(negedge clk);
    endtask

    // Multiplier on cp0: claims, takes a couple of cycles, then completes.
    task automatic test_mul(input string nm, input logic [31:0] insn,
                            input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp);
        logic        [63:0] up;
        logic signed [63:0] sp;
        logic        [31:0] res;
        @(negedge clk);
        pcpi_valid = 1'b1; pcpi_insn = insn; pcpi_rs1 = a; pcpi_rs2 = b;
        @(negedge clk);
        total++; if (cp_valid !== 1'b1) begin bad++; $display("FAIL %s_cp_valid got=%b want=1", nm, cp_valid); end
        total++; if ({cp_insn, cp_rs1, cp_rs2} !== {insn, a, b}) begin bad++; $display("FAIL %s_broadcast got=%h want=%h", nm, {cp_insn, cp_rs1, cp_rs2}, {insn, a, b}); end
        cp_wait[0] = pcpi_is_muldiv(cp_insn);
        @(negedge clk);
        total++; if (pcpi_wait !== 1'b1) begin bad++; $display("FAIL %s_wait got=%b want=1", nm, pcpi_wait); end
        up  = {32'd0, cp_rs1} * {32'd0, cp_rs2};
        sp  = $signed(cp_rs1) * $signed(cp_rs2);
        case (cp_insn[14:12])
            3'd1:    res = sp[63:32];
            3'd3:    res = up[63:32];
            default: res = up[31:0];
        endcase
        @(negedge clk);
        cp_ready[0] = 1'b1; cp_wr[0] = 1'b1; cp_rd[31:0] = res;
        @(negedge clk);
        total++; if ({pcpi_ready, pcpi_wr} !== 2'b11) begin bad++; $display("FAIL %s_ready_wr got=%b want=11", nm, {pcpi_ready, pcpi_wr}); end
        total++; if (pcpi_rd !== exp) begin bad++; $display("FAIL %s_rd got=%h want=%h", nm, pcpi_rd, exp); end
        total++; if ({cp_valid, pcpi_wait} !== 2'b00) begin bad++; $display("FAIL %s_resp_drop got=%b want=00", nm, {cp_valid, pcpi_wait}); end
        clear_cp(); pcpi_valid = 1'b0;
        @(negedge clk);
        total++; if (pcpi_ready !== 1'b0) begin bad++; $display("FAIL %s_one_pulse got=%b want=0", nm, pcpi_ready); end
        total++; if (pcpi_rd !== exp) begin bad++; $display("FAIL %s_rd_hold got=%h want=%h", nm, pcpi_rd, exp); end
        @(negedge clk);
    endtask

    task automatic test_timeout();
        int first = -1, pulses = 0, readys = 0, wrs = 0;
        logic cv15 = 1'b0;
        pcpi_state_e s16 = IDLE, s17 = ISSUE;
        @(negedge clk);
        pcpi_valid = 1'b1; pcpi_insn = 32'h0; pcpi_rs1 = 32'h1; pcpi_rs2 = 32'h2;
        for (int j = 0; j < 20; j++) begin
            @(negedge clk);
            if (pcpi_illegal) begin
                pulses++;
                if (first < 0) begin first = j; pcpi_valid = 1'b0; end
            end
            if (pcpi_ready) readys++;
            if (pcpi_wr) wrs++;
            if (j == 15) cv15 = cp_valid;
            if (j == 16) s16 = dut.state_q;
            if (j == 17) s17 = dut.state_q;
        end
        pcpi_valid = 1'b0;
        total++; if (first != 16) begin bad++; $display("FAIL timeout_edge got=%0d want=16", first); end
        total++; if (pulses != 1) begin bad++; $display("FAIL timeout_pulses got=%0d want=1", pulses); end
        total++; if ((readys != 0) || (wrs != 0)) begin bad++; $display("FAIL timeout_no_ready got=%0d/%0d want=0/0", readys, wrs); end
        total++; if (cv15 !== 1'b1) begin bad++; $display("FAIL timeout_cp_valid15 got=%b want=1", cv15); end
        total++; if (s16 !== GAP) begin bad++; $display("FAIL timeout_gap got=%0d want=%0d", s16, GAP); end
        total++; if (s17 !== IDLE) begin bad++; $display("FAIL timeout_idle got=%0d want=%0d", s17, IDLE); end
    endtask

    task automatic test_dual_ready();
        int pulses = 0;
        @(negedge clk);
        pcpi_valid = 1'b1; pcpi_insn = 32'h0000000B;
        @(negedge clk);
        cp_ready = 2'b11; cp_wr = 2'b11; cp_rd = {32'h22222222, 32'h11111111};
        @(negedge clk);
        total++; if (pcpi_rd !== 32'h11111111) begin bad++; $display("FAIL dual_rd got=%h want=11111111", pcpi_rd); end
        clear_cp(); pcpi_valid = 1'b0;
        if (pcpi_ready) pulses++;
        for (int j = 0; j < 4; j++) begin
            @(negedge clk);
            if (pcpi_ready) pulses++;
        end
        total++; if (pulses != 1) begin bad++; $display("FAIL dual_pulses got=%0d want=1", pulses); end
    endtask

    task automatic test_wait_and_ready();
        @(negedge clk);
        pcpi_valid = 1'b1; pcpi_insn = I_OTHER;
        @(negedge clk);
        cp_wait = 2'b10; cp_ready = 2'b01; cp_wr = 2'b00; cp_rd = {32'hFFFFFFFF, 32'h5A5A5A5A};
        @(negedge clk);
        total++; if (pcpi_ready !== 1'b1) begin bad++; $display("FAIL wait_ready_wins got=%b want=1", pcpi_ready); end
        total++; if ({pcpi_wr, pcpi_rd} !== {1'b0, 32'h5A5A5A5A}) begin bad++; $display("FAIL wait_ready_result got=%b/%h want=0/5a5a5a5a", pcpi_wr, pcpi_rd); end
        clear_cp(); pcpi_valid = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_last_cycle_ready();
        int rj = -1, ills = 0;
        logic [31:0] rd16 = '0;
        @(negedge clk);
        pcpi_valid = 1'b1; pcpi_insn = 32'h12345677;
        for (int j = 0; j < 20; j++) begin
            @(negedge clk);
            if (pcpi_illegal) ills++;
            if (pcpi_ready && rj < 0) begin rj = j; rd16 = pcpi_rd; clear_cp(); pcpi_valid = 1'b0; end
            if (j == 15) begin cp_ready[0] = 1'b1; cp_wr[0] = 1'b1; cp_rd[31:0] = 32'h0BADCAFE; end
        end
        clear_cp(); pcpi_valid = 1'b0;
        total++; if (rj != 16) begin bad++; $display("FAIL last_ready_edge got=%0d want=16", rj); end
        total++; if (ills != 0) begin bad++; $display("FAIL last_ready_illegal got=%0d want=0", ills); end
        total++; if (rd16 !== 32'h0BADCAFE) begin bad++; $display("FAIL last_ready_rd got=%h want=0badcafe", rd16); end
    endtask

    task automatic test_back_to_back();
        int first = -1;
        logic [31:0] ins [0:3];
        @(negedge clk);
        pcpi_valid = 1'b1; pcpi_insn = I_MUL; pcpi_rs1 = 32'd1; pcpi_rs2 = 32'd2;
        @(negedge clk);
        cp_ready[0] = 1'b1; cp_wr[0] = 1'b1; cp_rd[31:0] = 32'd2;
        for (int n = 0; n < 4; n++) begin
            @(negedge clk);
            if (n == 0) begin clear_cp(); pcpi_insn = I_OTHER; end
            if (cp_valid && first < 0) first = n;
            ins[n] = cp_insn;
        end
        total++; if (first != 3) begin bad++; $display("FAIL b2b_accept got=%0d want=3", first); end
        total++; if (ins[2] !== I_MUL) begin bad++; $display("FAIL b2b_insn_hold got=%h want=%h", ins[2], I_MUL); end
        total++; if (ins[3] !== I_OTHER) begin bad++; $display("FAIL b2b_insn_update got=%h want=%h", ins[3], I_OTHER); end
        cp_ready[1] = 1'b1; cp_wr[1] = 1'b1; cp_rd[63:32] = 32'hCAFEF00D;
        @(negedge clk);
        total++; if ({pcpi_ready, pcpi_rd} !== {1'b1, 32'hCAFEF00D}) begin bad++; $display("FAIL b2b_second got=%b/%h want=1/cafef00d", pcpi_ready, pcpi_rd); end
        clear_cp(); pcpi_valid = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset_mid_busy();
        @(negedge clk);
        pcpi_valid = 1'b1; pcpi_insn = I_MUL; pcpi_rs1 = 32'd9; pcpi_rs2 = 32'd9;
        @(negedge clk);
        cp_wait[0] = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        #1;
        total++; if ({cp_valid, pcpi_wait, pcpi_ready, pcpi_illegal, pcpi_wr} !== 5'b0) begin bad++; $display("FAIL midrst_flags got=%b want=00000", {cp_valid, pcpi_wait, pcpi_ready, pcpi_illegal, pcpi_wr}); end
        total++; if ({pcpi_rd, cp_insn} !== 64'd0) begin bad++; $display("FAIL midrst_regs got=%h want=0", {pcpi_rd, cp_insn}); end
        total++; if (dut.state_q !== IDLE) begin bad++; $display("FAIL midrst_state got=%0d want=%0d", dut.state_q, IDLE); end
        clear_cp(); pcpi_valid = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_mul("mul", I_MUL, 32'd7, 32'd6, 32'd42);
        test_mul("mulhu", I_MULHU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE);
        test_mul("mulh", I_MULH, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000);
        test_timeout();
        test_dual_ready();
        test_wait_and_ready();
        test_last_cycle_ready();
        test_back_to_back();
        test_reset_mid_busy();
        test_mul("mul_after_rst", I_MUL, 32'd3, 32'd5, 32'd15);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
